// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_seq
// Description : Command FIFO feeding a multi-cycle ALU. Each queued command
//               is sequenced through LOAD (alu_rst+alu_bgn), START (alu_bgn),
//               and RUN (RUN_CYCLES cycles); the ALU results are then
//               captured and held on a valid/ready result port.
//               Optional macro ALU_SEQ_OPCHK_EN: opcodes above 4'b0110 skip
//               the ALU and return an error result (res_flags = 3'b100).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_seq #(
  parameter int DEPTH      = 4,
  parameter int RUN_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [28:0] cmd_word,
  input  logic [15:0] cmd_b,
  output logic        alu_rst,
  output logic        alu_bgn,
  output logic [3:0]  alu_control,
  output logic [15:0] alu_nr1,
  output logic [15:0] alu_nr2,
  output logic [3:0]  alu_pos,
  output logic        alu_sh,
  input  logic [31:0] alu_outbus,
  input  logic [31:0] alu_neg,
  input  logic        alu_carry,
  input  logic        alu_borrow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [31:0] res_neg,
  output logic [2:0]  res_flags
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  // FIFO entry: {op[3:0], pos[3:0], sh, a[15:0], b[15:0]}
  localparam int EW = 41;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [EW-1:0] fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic          op_err;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    op_q;
  logic [3:0]    pos_q;
  logic          sh_q;
  logic [15:0]   a_q;
  logic [15:0]   b_q;
  logic          res_valid_q;
  logic [31:0]   res_data_q;
  logic [31:0]   res_neg_q;
  logic [2:0]    res_flags_q;

  // cmd_word[3:0] carries no field; b arrives on cmd_b
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_word[3:0];

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign head      = fifo_q[rd_ptr_q];

`ifdef ALU_SEQ_OPCHK_EN
  assign op_err = (head[40:37] > 4'b0110);
`else
  assign op_err = 1'b0;
`endif

  // FIFO storage: payload only, occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {cmd_word[28:4], cmd_b};
    end
  end

  // FIFO pointers and occupancy; reset discards everything queued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic for the command sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty) state_d = op_err ? S_HOLD : S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_HOLD;
      S_HOLD:  if (res_valid_q && res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, run counter, operand latch and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      pos_q       <= '0;
      sh_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_neg_q   <= '0;
      res_flags_q <= '0;
    end else begin
      state_q <= state_d;
      // Operands only change on a pop, so they hold from LOAD through RUN
      if (pop) begin
        op_q  <= head[40:37];
        pos_q <= head[36:33];
        sh_q  <= head[32];
        a_q   <= head[31:16];
        b_q   <= head[15:0];
      end
      if (pop && op_err) begin
        res_data_q  <= '0;
        res_neg_q   <= '0;
        res_flags_q <= 3'b100;
      end
      case (state_q)
        S_START: cnt_q <= CW'(RUN_CYCLES - 1);
        S_RUN: begin
          if (cnt_q == '0) begin
            res_data_q  <= alu_outbus;
            res_neg_q   <= alu_neg;
            res_flags_q <= {1'b0, alu_borrow, alu_carry};
            res_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          // The error path enters HOLD with valid low; raise it one edge later
          if (!res_valid_q)   res_valid_q <= 1'b1;
          else if (res_ready) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign alu_rst     = (state_q == S_LOAD);
  assign alu_bgn     = (state_q == S_LOAD) || (state_q == S_START);
  assign alu_control = op_q;
  assign alu_nr1     = a_q;
  assign alu_nr2     = b_q;
  assign alu_pos     = pos_q;
  assign alu_sh      = sh_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_neg     = res_neg_q;
  assign res_flags   = res_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_seq
// Description : Scoreboard bench for alu_cmd_seq with a combinational ALU
//               stub: outbus = {nr2, nr1}, neg = {control, pos, 0.., sh},
//               carry = sh, borrow = pos[0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_seq;

  localparam int DEPTH      = 4;
  localparam int RUN_CYCLES = 100;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] neg;
    logic [2:0]  flags;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  pos;
    logic        sh;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic [28:0] cmd_word = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_ready;
  logic        alu_rst, alu_bgn, alu_sh;
  logic [3:0]  alu_control, alu_pos;
  logic [15:0] alu_nr1, alu_nr2;
  logic [31:0] alu_outbus, alu_neg;
  logic        alu_carry, alu_borrow;
  logic        res_valid;
  logic [31:0] res_data, res_neg;
  logic [2:0]  res_flags;

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  alu_cmd_seq #(.DEPTH(DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_word(cmd_word), .cmd_b(cmd_b),
    .alu_rst(alu_rst), .alu_bgn(alu_bgn), .alu_control(alu_control),
    .alu_nr1(alu_nr1), .alu_nr2(alu_nr2), .alu_pos(alu_pos), .alu_sh(alu_sh),
    .alu_outbus(alu_outbus), .alu_neg(alu_neg),
    .alu_carry(alu_carry), .alu_borrow(alu_borrow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_neg(res_neg), .res_flags(res_flags)
  );

  // ALU stub
  assign alu_outbus = {alu_nr2, alu_nr1};
  assign alu_neg    = {alu_control, alu_pos, 23'b0, alu_sh};
  assign alu_carry  = alu_sh;
  assign alu_borrow = alu_pos[0];

  always #5 clk = ~clk;

  // Directed vectors: {op, pos, sh, a, b, exp_data, exp_neg, exp_flags}
  localparam vec_t V034 = {4'h3, 4'h0, 1'b0, 16'd15, 16'd3,
                           32'h0003_000F, 32'h3000_0000, 3'b000};
  localparam vec_t V037 = {4'h2, 4'h0, 1'b0, 16'd63, 16'd19,
                           32'h0013_003F, 32'h2000_0000, 3'b000};
`ifdef ALU_SEQ_OPCHK_EN
  localparam vec_t V038 = {4'h8, 4'h1, 1'b0, 16'd7, 16'd9,
                           32'h0000_0000, 32'h0000_0000, 3'b100};
`else
  localparam vec_t V038 = {4'h8, 4'h1, 1'b0, 16'd7, 16'd9,
                           32'h0009_0007, 32'h8100_0000, 3'b010};
`endif

  function automatic vec_t tbl(input int i);
    case (i)
      0:       return {4'h1, 4'h2, 1'b1, 16'h1234, 16'h5678, 32'h5678_1234, 32'h1200_0001, 3'b001};
      1:       return {4'h2, 4'h3, 1'b0, 16'hFFFF, 16'h0001, 32'h0001_FFFF, 32'h2300_0000, 3'b010};
      2:       return {4'h4, 4'h1, 1'b1, 16'h00AA, 16'hBB00, 32'hBB00_00AA, 32'h4100_0001, 3'b011};
      3:       return {4'h5, 4'h0, 1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 32'h5000_0000, 3'b000};
      4:       return {4'h6, 4'hF, 1'b1, 16'h8001, 16'h7FFE, 32'h7FFE_8001, 32'h6F00_0001, 3'b011};
      default: return {4'h1, 4'h0, 1'b0, 16'h0001, 16'h0001, 32'h0001_0001, 32'h1000_0000, 3'b000};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"},   cmd_ready,   1);
    chk({tag, "_alu_rst"},     alu_rst,     0);
    chk({tag, "_alu_bgn"},     alu_bgn,     0);
    chk({tag, "_alu_control"}, alu_control, 0);
    chk({tag, "_alu_nr1"},     alu_nr1,     0);
    chk({tag, "_alu_nr2"},     alu_nr2,     0);
    chk({tag, "_alu_pos"},     alu_pos,     0);
    chk({tag, "_alu_sh"},      alu_sh,      0);
    chk({tag, "_res_valid"},   res_valid,   0);
    chk({tag, "_res_data"},    res_data,    0);
    chk({tag, "_res_neg"},     res_neg,     0);
    chk({tag, "_res_flags"},   res_flags,   0);
  endtask

  task automatic drive(input vec_t v);
    cmd_word = {v.op, v.pos, v.sh, v.a, 4'b0};
    cmd_b    = v.b;
  endtask

  // Returns #1 after the accepting edge
  task automatic send(input vec_t v, input bit expect_res);
    int w;
    w = 0;
    drive(v);
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!cmd_ready && w < 50);
    if (w >= 50) chk("send_ready_timeout", cmd_ready, 1);
    @(posedge clk);
    if (expect_res) sb.push_back(v.e);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Edge k after the accepting edge; samples taken mid-cycle
  task automatic measure(input logic [35:0] ops_exp,
                         output logic [1:0] p1, output logic [1:0] p2,
                         output logic [1:0] p3, output int rise,
                         output int bgn_cnt, output int ops_bad);
    rise = -1; bgn_cnt = 0; ops_bad = 0; p1 = 2'bxx; p2 = 2'bxx; p3 = 2'bxx;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) p1 = {alu_rst, alu_bgn};
      if (k == 2) p2 = {alu_rst, alu_bgn};
      if (k == 3) p3 = {alu_rst, alu_bgn};
      if (alu_bgn) bgn_cnt++;
      if (res_valid) begin
        rise = k;
        break;
      end
      if ({alu_control, alu_nr1, alu_nr2} !== ops_exp) ops_bad++;
    end
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (sb.size() != 0 && w < 2000);
    chk({tag, "_drained"}, sb.size(), 0);
  endtask

  // Scoreboard monitor: pops one expectation per result handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_result: got data 0x%0h flags %b, want none", res_data, res_flags);
        end else begin
          e = sb.pop_front();
          chk("res_data",  res_data,  e.data);
          chk("res_neg",   res_neg,   e.neg);
          chk("res_flags", res_flags, e.flags);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] p1, p2, p3;
    int rise, bgn_cnt, ops_bad, acc, bad, lds, w;
    logic rdy;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset("in_reset");
    rst = 1'b1;
    @(negedge clk);
    chk_reset("after_release");

    // Single op into idle block: strobe pattern and latency
    res_ready = 1'b1;
    @(posedge clk); #1;
    send(V034, 1'b1);
    measure({4'h3, 16'd15, 16'd3}, p1, p2, p3, rise, bgn_cnt, ops_bad);
    chk("t034_load_strobes",  p1, 2'b11);
    chk("t034_start_strobes", p2, 2'b01);
    chk("t034_run_strobes",   p3, 2'b00);
    chk("t034_bgn_cycles",    bgn_cnt, 2);
    chk("t034_latency",       rise, RUN_CYCLES + 3);
    chk("t034_operands_held", ops_bad, 0);
    drain("t034");

    // Back-pressure: result stalled, commands streamed until FIFO full
    @(posedge clk); #1;
    res_ready = 1'b0;
    acc = 0;
    drive(tbl(0));
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        if (acc < 6) sb.push_back(tbl(acc).e);
        acc++;
        if (acc < 6) drive(tbl(acc));
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t035_accepted", acc, DEPTH + 1);
    chk("t035_ready_low", cmd_ready, 0);

    // Result held while res_ready is low; next LOAD after handshake
    w = 0;
    while (!res_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("t036_res_valid_seen", res_valid, 1);
    bad = 0; lds = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== tbl(0).e.data || res_flags !== tbl(0).e.flags) bad++;
      if (alu_rst) lds++;
    end
    chk("t036_hold_stable", bad, 0);
    chk("t036_no_load_while_held", lds, 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk);                       // handshake edge
    @(negedge clk);
    chk("t036_valid_dropped", res_valid, 0);
    chk("t036_idle_after_hs", alu_rst, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t036_load_before_edge2", alu_rst, 1);
    drain("t036");

    // Asynchronous reset in the middle of RUN with commands still queued
    @(posedge clk); #1;
    send(V037, 1'b0);
    send(tbl(1), 1'b0);
    send(tbl(2), 1'b0);
    repeat (25) @(negedge clk);
    chk("t037_in_flight_nr1", alu_nr1, 63);
    chk("t037_in_flight_nr2", alu_nr2, 19);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("t037_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bad = 0; lds = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (res_valid) bad++;
      if (alu_rst || alu_bgn) lds++;
    end
    chk("t037_no_result", bad, 0);
    chk("t037_queue_flushed", lds, 0);
    chk("t037_cmd_ready", cmd_ready, 1);

    // Out-of-range opcode
    @(posedge clk); #1;
    send(V038, 1'b1);
    measure({4'h8, 16'd7, 16'd9}, p1, p2, p3, rise, bgn_cnt, ops_bad);
`ifdef ALU_SEQ_OPCHK_EN
    chk("t038_err_latency", rise, 2);
    chk("t038_err_no_bgn",  bgn_cnt, 0);
`else
    chk("t038_latency",       rise, RUN_CYCLES + 3);
    chk("t038_bgn_cycles",    bgn_cnt, 2);
    chk("t038_load_strobes",  p1, 2'b11);
`endif
    drain("t038");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
